// File: rtl/micro_seq_if.sv
// Connection bundle between the microprogram sequencer, its control store,
// the instruction decoder, the ALU flags and the memory interface.
interface micro_seq_if #(
  parameter int AW = 5,
  parameter int CW = 29
);
  logic [CW-1:0] cwrd;
  logic [AW-1:0] ib;
  logic [3:0]    cc;
  logic          mem_ack;
  logic          start;
  logic [AW-1:0] upc;
  logic          mem_req;
  logic          halted;
  logic          stack_err;

  modport master (
    input  cwrd, ib, cc, mem_ack, start,
    output upc, mem_req, halted, stack_err
  );

  modport slave (
    output cwrd, ib, cc, mem_ack, start,
    input  upc, mem_req, halted, stack_err
  );
endinterface

// File: rtl/micro_seq.sv
// Microprogram sequencer: micro-PC, next-address selection, memory-handshake
// stalls, halt/restart and a small micro-subroutine return stack.
module micro_seq #(
  parameter int AW = 5,
  parameter int CW = 29,
  parameter int SD = 4
) (
  input  logic        clk,
  input  logic        rst,
  micro_seq_if.master bus
);
  localparam int SPW = $clog2(SD + 1);
  localparam int IW  = (SD > 1) ? $clog2(SD) : 1;
  localparam logic [SPW-1:0] SP_EMPTY = {SPW{1'b0}};
  localparam logic [SPW-1:0] SP_ONE   = SPW'(1'b1);
  localparam logic [SPW-1:0] SP_FULL  = SPW'(SD);
  localparam logic [AW-1:0]  UPC_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]  UPC_ONE  = AW'(1'b1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [AW-1:0]  upc_r;
  logic [AW-1:0]  stack_r [SD];
  logic [SPW-1:0] sp_r;
  logic           stack_err_r;

  logic [AW-1:0]  tgt_s;
  logic [AW-1:0]  inc_s;
  logic [AW-1:0]  sel_addr_s;
  logic [AW-1:0]  next_addr_s;
  logic [3:0]     mask_s;
  logic [1:0]     sel_s;
  logic           do_mem_s;
  logic           do_halt_s;
  logic           do_call_s;
  logic           do_ret_s;
  logic           cond_taken_s;
  logic           advance_s;
  logic           restart_s;
  logic           mem_req_s;
  logic [IW-1:0]  top_idx_s;
  logic [IW-1:0]  push_idx_s;
  logic           unused_bits_s;

  assign tgt_s         = bus.cwrd[AW-1:0];
  assign sel_s         = bus.cwrd[6:5];
  assign mask_s        = bus.cwrd[10:7];
  assign do_mem_s      = bus.cwrd[11];
  assign do_halt_s     = bus.cwrd[12];
  assign do_call_s     = bus.cwrd[13];
  assign do_ret_s      = bus.cwrd[14];
  assign unused_bits_s = ^bus.cwrd[CW-1:15];

  // Next-address selection; a return always overrides the select field
  always_comb begin
    inc_s        = upc_r + UPC_ONE;
    cond_taken_s = |(bus.cc & mask_s);
    top_idx_s    = IW'(sp_r - SP_ONE);
    push_idx_s   = IW'(sp_r);
    case (sel_s)
      2'b00:   sel_addr_s = bus.ib;
      2'b01:   sel_addr_s = inc_s;
      2'b10:   sel_addr_s = cond_taken_s ? tgt_s : inc_s;
      2'b11:   sel_addr_s = tgt_s;
      default: sel_addr_s = inc_s;
    endcase
    if (do_ret_s) begin
      if (sp_r != SP_EMPTY) begin
        next_addr_s = stack_r[top_idx_s];
      end else begin
        next_addr_s = inc_s;
      end
    end else begin
      next_addr_s = sel_addr_s;
    end
  end

  // Sequencer FSM next state, advance/restart strobes and memory request
  always_comb begin
    state_nxt_s = state_r;
    advance_s   = 1'b0;
    restart_s   = 1'b0;
    mem_req_s   = 1'b0;
    case (state_r)
      RUN: begin
        mem_req_s = do_mem_s & ~do_halt_s;
        if (do_halt_s) begin
          state_nxt_s = HALT;
        end else if (do_mem_s && !bus.mem_ack) begin
          state_nxt_s = MEMWAIT;
        end else begin
          advance_s = 1'b1;
        end
      end
      MEMWAIT: begin
        mem_req_s = 1'b1;
        if (bus.mem_ack) begin
          advance_s   = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = MEMWAIT;
        end
      end
      HALT: begin
        if (bus.start) begin
          restart_s   = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = HALT;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // State, micro-PC and return-stack registers; the stack moves only when upc advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      upc_r       <= UPC_ZERO;
      sp_r        <= SP_EMPTY;
      stack_err_r <= 1'b0;
      for (int i = 0; i < SD; i++) begin
        stack_r[i] <= UPC_ZERO;
      end
    end else begin
      state_r <= state_nxt_s;
      if (restart_s) begin
        upc_r <= UPC_ZERO;
      end else if (advance_s) begin
        upc_r <= next_addr_s;
        if (do_ret_s) begin
          if (sp_r != SP_EMPTY) begin
            sp_r <= sp_r - SP_ONE;
          end else begin
            stack_err_r <= 1'b1;
          end
        end else if (do_call_s) begin
          if (sp_r == SP_FULL) begin
            stack_err_r <= 1'b1;
          end else begin
            stack_r[push_idx_s] <= inc_s;
            sp_r                <= sp_r + SP_ONE;
          end
        end
      end
    end
  end

  assign bus.upc       = upc_r;
  assign bus.mem_req   = mem_req_s;
  assign bus.halted    = (state_r == HALT);
  assign bus.stack_err = stack_err_r;
endmodule

// File: tb/tb_micro_seq.sv
// Scenario bench for micro_seq: a bench-side control store feeds cwrd from upc,
// expected micro-addresses are queued as stimulus is applied and popped per edge.
module tb_micro_seq;
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_MEM  = 4'b0001;
  localparam logic [3:0] F_HALT = 4'b0010;
  localparam logic [3:0] F_CALL = 4'b0100;
  localparam logic [3:0] F_RET  = 4'b1000;

  logic clk;
  logic rst;
  logic [28:0] rom [32];
  logic [4:0]  exp_q [$];
  logic        err_q [$];
  logic [4:0]  e;
  logic        ee;
  int          cmps;
  int          errs;

  micro_seq_if #(.AW(5), .CW(29)) bus ();

  micro_seq #(.AW(5), .CW(29), .SD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.cwrd = rom[bus.upc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {ignored, ret, call, halt, mem, mask, sel, target}
  function automatic logic [28:0] cw(input logic [3:0] fl, input logic [3:0] mask,
                                     input logic [1:0] sel, input logic [4:0] tgt);
    logic [13:0] junk;
    junk = 14'($urandom);
    return {junk, fl, mask, sel, tgt};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = cw(F_NONE, 4'd0, 2'b01, 5'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.ib      = 5'd0;
    bus.cc      = 4'd0;
    bus.mem_ack = 1'b0;
    bus.start   = 1'b0;
    clear_rom();
    rom[0] = cw(F_MEM, 4'd0, 2'b01, 5'd0);
    #2;
    cmps++;
    if (bus.upc !== 5'd0) begin $display("FAIL reset_upc: got %0d expected 0", bus.upc); errs++; end
    cmps++;
    if (bus.halted !== 1'b0 || bus.stack_err !== 1'b0) begin
      $display("FAIL reset_flags: got halted=%b stack_err=%b expected 0/0", bus.halted, bus.stack_err); errs++;
    end
    cmps++;
    if (bus.mem_req !== 1'b1) begin $display("FAIL reset_memreq_comb: got %b expected 1", bus.mem_req); errs++; end
    rom[0] = cw(F_NONE, 4'd0, 2'b01, 5'd0);
    rst = 1'b0;
  endtask

  task automatic test_seq();
    clear_rom();
    rom[3] = cw(F_NONE, 4'd0, 2'b11, 5'd31);
    do_reset();
    for (int i = 1; i <= 3; i++) exp_q.push_back(5'(i));
    exp_q.push_back(5'd31);
    exp_q.push_back(5'd0);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      cmps++;
      if (bus.upc !== e) begin $display("FAIL seq_upc: got %0d expected %0d", bus.upc, e); errs++; end
    end
  endtask

  task automatic test_cond();
    logic [3:0] cc_tab [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1111};
    logic [4:0] up_tab [6] = '{5'd4, 5'd12, 5'd4, 5'd5, 5'd9, 5'd10};
    clear_rom();
    rom[0]  = cw(F_NONE, 4'd0, 2'b11, 5'd4);
    rom[4]  = cw(F_NONE, 4'b0001, 2'b10, 5'd12);
    rom[12] = cw(F_NONE, 4'd0, 2'b11, 5'd4);
    rom[5]  = cw(F_NONE, 4'd0, 2'b00, 5'd17);
    rom[9]  = cw(F_NONE, 4'b0000, 2'b10, 5'd20);
    bus.ib = 5'd9;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.cc = cc_tab[i];
      exp_q.push_back(up_tab[i]);
      step();
      e = exp_q.pop_front();
      cmps++;
      if (bus.upc !== e) begin $display("FAIL cond_upc[%0d]: got %0d expected %0d", i, bus.upc, e); errs++; end
    end
  endtask

  task automatic test_mem();
    clear_rom();
    rom[0] = cw(F_NONE, 4'd0, 2'b11, 5'd6);
    rom[6] = cw(F_MEM, 4'd0, 2'b01, 5'd0);
    rom[7] = cw(F_MEM, 4'd0, 2'b01, 5'd0);
    bus.mem_ack = 1'b0;
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack = (i == 3);
      exp_q.push_back(5'd6);
      #1;
      e = exp_q.pop_front();
      cmps++;
      if (bus.mem_req !== 1'b1 || bus.upc !== e) begin
        $display("FAIL mem_wait[%0d]: got req=%b upc=%0d expected req=1 upc=%0d", i, bus.mem_req, bus.upc, e); errs++;
      end
      step();
    end
    cmps++;
    if (bus.upc !== 5'd7 || bus.mem_req !== 1'b1) begin
      $display("FAIL mem_done: got upc=%0d req=%b expected upc=7 req=1", bus.upc, bus.mem_req); errs++;
    end
    step();
    cmps++;
    if (bus.upc !== 5'd8 || bus.mem_req !== 1'b0) begin
      $display("FAIL mem_zero_wait: got upc=%0d req=%b expected upc=8 req=0", bus.upc, bus.mem_req); errs++;
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_call();
    logic [4:0] up_tab [9] = '{5'd2, 5'd20, 5'd3, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd24};
    logic       er_tab [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    clear_rom();
    rom[0]  = cw(F_NONE, 4'd0, 2'b11, 5'd2);
    rom[2]  = cw(F_CALL, 4'd0, 2'b11, 5'd20);
    rom[20] = cw(F_RET, 4'd0, 2'b11, 5'd30);
    rom[3]  = cw(F_CALL, 4'd0, 2'b11, 5'd21);
    rom[21] = cw(F_CALL, 4'd0, 2'b11, 5'd22);
    rom[22] = cw(F_CALL, 4'd0, 2'b11, 5'd23);
    rom[23] = cw(F_CALL, 4'd0, 2'b11, 5'd24);
    rom[24] = cw(F_CALL, 4'd0, 2'b11, 5'd25);
    rom[25] = cw(F_RET, 4'd0, 2'b11, 5'd1);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(up_tab[i]);
      err_q.push_back(er_tab[i]);
      step();
      e  = exp_q.pop_front();
      ee = err_q.pop_front();
      cmps++;
      if (bus.upc !== e || bus.stack_err !== ee) begin
        $display("FAIL call[%0d]: got upc=%0d err=%b expected upc=%0d err=%b", i, bus.upc, bus.stack_err, e, ee); errs++;
      end
    end
  endtask

  task automatic test_underflow();
    logic [4:0] up_tab [3] = '{5'd8, 5'd9, 5'd10};
    logic       er_tab [3] = '{1'b0, 1'b1, 1'b1};
    clear_rom();
    rom[0] = cw(F_NONE, 4'd0, 2'b11, 5'd8);
    rom[8] = cw(F_RET, 4'd0, 2'b11, 5'd30);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(up_tab[i]);
      err_q.push_back(er_tab[i]);
      step();
      e  = exp_q.pop_front();
      ee = err_q.pop_front();
      cmps++;
      if (bus.upc !== e || bus.stack_err !== ee) begin
        $display("FAIL underflow[%0d]: got upc=%0d err=%b expected upc=%0d err=%b", i, bus.upc, bus.stack_err, e, ee); errs++;
      end
    end
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0]  = cw(F_NONE, 4'd0, 2'b11, 5'd10);
    rom[10] = cw(F_HALT | F_MEM, 4'd0, 2'b11, 5'd3);
    bus.start   = 1'b0;
    bus.mem_ack = 1'b0;
    do_reset();
    step();
    cmps++;
    if (bus.upc !== 5'd10 || bus.mem_req !== 1'b0 || bus.halted !== 1'b0) begin
      $display("FAIL halt_word: got upc=%0d req=%b halted=%b expected 10/0/0", bus.upc, bus.mem_req, bus.halted); errs++;
    end
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(5'd10);
      step();
      e = exp_q.pop_front();
      cmps++;
      if (bus.upc !== e || bus.halted !== 1'b1 || bus.mem_req !== 1'b0) begin
        $display("FAIL halt_hold[%0d]: got upc=%0d halted=%b req=%b expected %0d/1/0", i, bus.upc, bus.halted, bus.mem_req, e); errs++;
      end
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cmps++;
    if (bus.upc !== 5'd0 || bus.halted !== 1'b0) begin
      $display("FAIL halt_restart: got upc=%0d halted=%b expected 0/0", bus.upc, bus.halted); errs++;
    end
    step();
    cmps++;
    if (bus.upc !== 5'd10) begin $display("FAIL halt_rerun: got %0d expected 10", bus.upc); errs++; end
  endtask

  task automatic test_rst_memwait();
    clear_rom();
    rom[0] = cw(F_NONE, 4'd0, 2'b11, 5'd6);
    rom[6] = cw(F_MEM, 4'd0, 2'b01, 5'd0);
    bus.mem_ack = 1'b0;
    do_reset();
    step();
    step();
    cmps++;
    if (bus.upc !== 5'd6 || bus.mem_req !== 1'b1) begin
      $display("FAIL memwait_entry: got upc=%0d req=%b expected 6/1", bus.upc, bus.mem_req); errs++;
    end
    rst = 1'b1;
    #1;
    cmps++;
    if (bus.upc !== 5'd0 || bus.mem_req !== 1'b0 || bus.halted !== 1'b0) begin
      $display("FAIL memwait_reset: got upc=%0d req=%b halted=%b expected 0/0/0", bus.upc, bus.mem_req, bus.halted); errs++;
    end
    #1;
    rst = 1'b0;
  endtask

  initial begin
    cmps = 0;
    errs = 0;
    test_reset();
    test_seq();
    test_cond();
    test_mem();
    test_call();
    test_underflow();
    test_halt();
    test_rst_memwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
